// File: rtl/ram_ctrl_pkg.sv
// Shared layout for the matrix RAM controllers.
// Holds the bus packet shape (beats per packet, which beats carry data, packets
// per transfer), the per-data-beat RAM address and lane-keep tables, the read
// FSM state encoding and a lane-masking helper. The write controller imports
// the same constants so both ends agree on where each matrix element lives.
package ram_ctrl_pkg;

    localparam int BEATS   = 10;
    localparam int PKT_NUM = 3;
    localparam int ENTRIES = PKT_NUM * 2;

    // bit b set: beat b of every packet carries RAM data
    localparam logic [BEATS-1:0] BUS_DATA_VLD = 10'b00_0000_0110;

    localparam logic [3:0] BEAT_LAST = 4'(BEATS - 1);
    localparam logic [1:0] PKT_LAST  = 2'(PKT_NUM - 1);

    // RAM address and lane keep mask per data beat, in consumption order.
    // Mask bit0 keeps [15:0], bit1 keeps [31:16].
    localparam logic [3:0] RADDR [0:ENTRIES-1] = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8};
    localparam logic [1:0] RD_STRB [0:ENTRIES-1] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEXT  = 3'd1,
        ST_RREQ  = 3'd2,
        ST_RWAIT = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } rd_state_e;

    function automatic logic [31:0] mask_lanes(input logic [31:0] data, input logic [1:0] strb);
        return {(strb[1] ? data[31:16] : 16'h0000), (strb[0] ? data[15:0] : 16'h0000)};
    endfunction

endpackage

// File: rtl/ram_rd_control_if.sv
// Downstream packet bus of the matrix RAM read controller.
//   rd_sop  : first beat of a packet (qualified by rd_vld)
//   rd_eop  : last beat of a packet (qualified by rd_vld)
//   rd_vld  : beat valid
//   rd_rdy  : downstream accept; a beat transfers when rd_vld & rd_rdy
//   rd_data : beat payload, zero on non-data beats
// master = packet source (controller), slave = packet sink.
interface ram_rd_control_if;
    logic        rd_sop;
    logic        rd_eop;
    logic        rd_vld;
    logic        rd_rdy;
    logic [31:0] rd_data;

    modport master (
        output rd_sop,
        output rd_eop,
        output rd_vld,
        output rd_data,
        input  rd_rdy
    );

    modport slave (
        input  rd_sop,
        input  rd_eop,
        input  rd_vld,
        input  rd_data,
        output rd_rdy
    );
endinterface

// File: rtl/ram_rd_control.sv
// Matrix RAM read controller.
// On start, reads the 3x3 matrix of 16-bit elements from the 2-lane RAM and
// emits it as PKT_NUM packets of BEATS beats, RAM data on the beats flagged in
// BUS_DATA_VLD, zero elsewhere. Outputs are registered and held while the
// downstream stalls.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : 1-cycle pulse, begins a transfer (ignored while busy)
//   busy         : transfer in progress
//   done         : 1-cycle pulse after the last beat is accepted
//   ram_rd_en    : RAM read strobe
//   ram_rd_addr  : RAM read address (0 when ram_rd_en=0)
//   ram_rd_data  : RAM read data, valid one cycle after ram_rd_en
//   rd           : packet bus, master side
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for start, counters cleared
// ST_NEXT  | decide whether the current beat needs RAM data
// ST_RREQ  | RAM read strobe out for the current table entry
// ST_RWAIT | RAM data arrives, lanes masked and captured
// ST_SEND  | beat presented, held until rd_rdy
// ST_DONE  | done pulse, then back to idle
module ram_rd_control
    import ram_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_rd_en,
    output logic [3:0]               ram_rd_addr,
    input  logic [31:0]              ram_rd_data,
    ram_rd_control_if.master         rd
);

    rd_state_e   state_q, state_d;
    logic [3:0]  beat_q, beat_d;
    logic [1:0]  pkt_q, pkt_d;
    logic [2:0]  entry_q, entry_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ram_rd_en_q, ram_rd_en_d;
    logic [3:0]  ram_rd_addr_q, ram_rd_addr_d;
    logic        rd_sop_q, rd_sop_d;
    logic        rd_eop_q, rd_eop_d;
    logic        rd_vld_q, rd_vld_d;
    logic [31:0] rd_data_q, rd_data_d;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        entry_d = entry_q;

        unique case (state_q)
            ST_IDLE: begin
                beat_d  = 4'd0;
                pkt_d   = 2'd0;
                entry_d = 3'd0;
                if (start) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = BUS_DATA_VLD[beat_q] ? ST_RREQ : ST_SEND;
            end
            ST_RREQ: begin
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                entry_d = entry_q + 3'd1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (rd.rd_rdy) begin
                    if (beat_q != BEAT_LAST) begin
                        beat_d  = beat_q + 4'd1;
                        state_d = ST_NEXT;
                    end else if (pkt_q != PKT_LAST) begin
                        beat_d  = 4'd0;
                        pkt_d   = pkt_q + 2'd1;
                        state_d = ST_NEXT;
                    end else begin
                        beat_d  = 4'd0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register. beat_q never changes on entry to or while in SEND, so it is
    // the beat being presented.
    always_comb begin
        busy_d        = (state_d == ST_NEXT) || (state_d == ST_RREQ) ||
                        (state_d == ST_RWAIT) || (state_d == ST_SEND);
        done_d        = (state_d == ST_DONE);
        ram_rd_en_d   = (state_d == ST_RREQ);
        ram_rd_addr_d = (state_d == ST_RREQ) ? RADDR[entry_q] : 4'd0;
        rd_vld_d      = (state_d == ST_SEND);
        rd_sop_d      = (state_d == ST_SEND) && (beat_q == 4'd0);
        rd_eop_d      = (state_d == ST_SEND) && (beat_q == BEAT_LAST);

        rd_data_d = 32'h0;
        if (state_d == ST_SEND) begin
            if (state_q == ST_SEND) begin
                rd_data_d = rd_data_q;
            end else if (state_q == ST_RWAIT) begin
                rd_data_d = mask_lanes(ram_rd_data, RD_STRB[entry_q]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_q        <= 4'd0;
            pkt_q         <= 2'd0;
            entry_q       <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= 4'd0;
            rd_sop_q      <= 1'b0;
            rd_eop_q      <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_data_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            pkt_q         <= pkt_d;
            entry_q       <= entry_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            rd_sop_q      <= rd_sop_d;
            rd_eop_q      <= rd_eop_d;
            rd_vld_q      <= rd_vld_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;
    assign rd.rd_sop   = rd_sop_q;
    assign rd.rd_eop   = rd_eop_q;
    assign rd.rd_vld   = rd_vld_q;
    assign rd.rd_data  = rd_data_q;

endmodule

// File: tb/tb_ram_rd_control.sv
// Bench for ram_rd_control: expected beats and RAM addresses are queued when a
// transfer is started; a negedge monitor pops and compares on every accepted
// beat and every RAM read strobe, and checks outputs stay put while stalled.
module tb_ram_rd_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        ram_rd_en;
    logic [3:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;

    ram_rd_control_if bus ();

    ram_rd_control dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .rd          (bus.master)
    );

    always #5 clk = ~clk;

    // RAM model: element i = 16'h1000+i, address a returns {elem a+1, elem a}
    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rd_data <= {16'h1000 + 16'(ram_rd_addr) + 16'd1, 16'h1000 + 16'(ram_rd_addr)};
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [33:0] exp_q[$];   // {sop, eop, data}
    logic [3:0]  addr_q[$];

    int   acc_cnt   = 0;
    int   rden_cnt  = 0;
    int   done_cnt  = 0;
    bit   p1b2_seen = 0;
    bit   stall_prev = 0;
    logic [34:0] prev_out;
    int   rdy_mode  = 1;   // 0 low, 1 high, 2 random

    always @(negedge clk) begin
        if (!rst) begin
            logic [33:0] e;
            logic [3:0]  a;
            p1b2_seen = bus.rd_vld && (acc_cnt == 12);
            if (stall_prev) begin
                chk("stall_stable", {29'h0, bus.rd_sop, bus.rd_eop, bus.rd_vld, bus.rd_data}, {29'h0, prev_out});
            end
            if (bus.rd_vld && bus.rd_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", acc_cnt), {30'h0, bus.rd_sop, bus.rd_eop, bus.rd_data}, {30'h0, e});
                end
                acc_cnt++;
            end
            if (!bus.rd_vld) begin
                chk("idle_bus_zero", {30'h0, bus.rd_sop, bus.rd_eop, bus.rd_data}, 64'h0);
            end
            if (ram_rd_en) begin
                if (addr_q.size() == 0) begin
                    chk("rd_en_unexpected", 64'd1, 64'd0);
                end else begin
                    a = addr_q.pop_front();
                    chk($sformatf("raddr%0d", rden_cnt), {60'h0, ram_rd_addr}, {60'h0, a});
                end
                rden_cnt++;
            end else begin
                chk("raddr_idle_zero", {60'h0, ram_rd_addr}, 64'h0);
            end
            if (done) done_cnt++;
            stall_prev = bus.rd_vld && !bus.rd_rdy;
            prev_out   = {bus.rd_sop, bus.rd_eop, bus.rd_vld, bus.rd_data};
        end else begin
            stall_prev = 0;
            p1b2_seen  = 0;
        end
    end

    initial begin
        bus.rd_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rd_rdy = 1'b0;
                1:       bus.rd_rdy = 1'b1;
                default: bus.rd_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Expected stream: pkt p beat1 = {elem 3p+1, elem 3p}, beat2 = {0, elem 3p+2}
    task automatic push_expected();
        logic [3:0] addrs [0:5];
        addrs = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8};
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 10; b++) begin
                logic [15:0] base;
                logic [31:0] d;
                base = 16'h1000 + 16'(3 * p);
                d = 32'h0;
                if (b == 1) d = {base + 16'd1, base};
                if (b == 2) d = {16'h0000, base + 16'd2};
                exp_q.push_back({(b == 0), (b == 9), d});
            end
        end
        for (int i = 0; i < 6; i++) addr_q.push_back(addrs[i]);
        acc_cnt  = 0;
        rden_cnt = 0;
        done_cnt = 0;
    endtask

    // Start pulse, then check busy the next cycle and first rd_vld two cycles on.
    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", {63'h0, busy}, 64'd1);
        chk("vld_latency_early", {63'h0, bus.rd_vld}, 64'd0);
        @(posedge clk);
        #1;
        chk("vld_latency_2", {63'h0, bus.rd_vld}, 64'd1);
        chk("first_sop", {63'h0, bus.rd_sop}, 64'd1);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt == 0) chk({name, "_done_timeout"}, 64'd0, 64'd1);
        repeat (5) @(negedge clk);
        #1;
        chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({name, "_rd_en_count"}, 64'(rden_cnt), 64'd6);
        chk({name, "_beats"}, 64'(acc_cnt), 64'd30);
        chk({name, "_busy_after"}, {63'h0, busy}, 64'd0);
        chk({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"}, {63'h0, busy}, 64'd0);
        chk({name, "_done"}, {63'h0, done}, 64'd0);
        chk({name, "_rd_en"}, {63'h0, ram_rd_en}, 64'd0);
        chk({name, "_raddr"}, {60'h0, ram_rd_addr}, 64'd0);
        chk({name, "_vld"}, {63'h0, bus.rd_vld}, 64'd0);
        chk({name, "_sop_eop"}, {62'h0, bus.rd_sop, bus.rd_eop}, 64'd0);
        chk({name, "_data"}, {32'h0, bus.rd_data}, 64'd0);
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic: downstream always ready
        rdy_mode = 1;
        push_expected();
        do_start();
        wait_done("basic");

        // Random backpressure
        rdy_mode = 2;
        push_expected();
        do_start();
        wait_done("backpressure");

        // start pulsed during pkt1 is ignored
        rdy_mode = 1;
        push_expected();
        do_start();
        k = 0;
        while (acc_cnt < 12 && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_start_ignored", {63'h0, busy}, 64'd1);
        wait_done("restart_ignored");

        // rd_rdy held low: beat 0 stalls, no RAM reads
        rdy_mode = 0;
        push_expected();
        do_start();
        repeat (30) @(negedge clk);
        #1;
        chk("stall_no_reads", 64'(rden_cnt), 64'd0);
        chk("stall_vld_held", {63'h0, bus.rd_vld}, 64'd1);
        chk("stall_no_beats", 64'(acc_cnt), 64'd0);
        rdy_mode = 1;
        wait_done("stall");

        // Async reset while pkt1 beat2 is presented, then a clean transfer
        rdy_mode = 1;
        push_expected();
        do_start();
        k = 0;
        while (!p1b2_seen && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!p1b2_seen) chk("p1b2_timeout", 64'd0, 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_expected();
        do_start();
        wait_done("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
